// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply/divide controller:
// operation codes, FSM state encoding and the default operand width.
// Optional feature macro: MULDIV_EARLY_OUT_EN (see muldiv_ctrl.sv).
package muldiv_ctrl_pkg;

  localparam int MULDIV_DATA_SIZE = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } muldiv_state_e;

  // Signed variants need magnitude conversion and a sign fix-up at the end
  function automatic logic op_is_signed(input muldiv_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, try to subtract the divisor, and keep the result
// only when it does not go negative. The quotient register doubles as
// the dividend shift register, so its LSB receives the new quotient bit.
module muldiv_ctrl_div_step
  import muldiv_ctrl_pkg::*;
#(
  parameter int DATA_W = MULDIV_DATA_SIZE
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quot_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quot_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // Trial subtraction on a DATA_W+1-bit partial remainder; the top bit of the difference is the borrow
  always_comb begin
    shifted = {rem_i, quot_i[DATA_W-1]};
    diff    = shifted - {1'b0, divisor_i};
    if (diff[DATA_W]) begin
      rem_o  = shifted[DATA_W-1:0];
      quot_o = {quot_i[DATA_W-2:0], 1'b0};
    end else begin
      rem_o  = diff[DATA_W-1:0];
      quot_o = {quot_i[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage MULT/MULTU/DIV/DIVU sequencer. Holds the pipeline while an
// operation runs, then pulses hilo_we_o for one cycle with HI/LO.
// Signed operations work on magnitudes and fix up signs at the end.
// Optional: define MULDIV_EARLY_OUT_EN to finish divides with |b| > |a|
// straight away (LO=0, HI=a) instead of running all DATA_W iterations.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int DATA_W  = MULDIV_DATA_SIZE,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  input  logic              flush_i,
  output logic              stall_req_o,
  output logic              hilo_we_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              busy_o,
  output logic              div_zero_o
);

  // Counter must hold both DATA_W-1 and MUL_LAT-1 (at most 7)
  localparam int CNT_W = ($clog2(DATA_W) > 3) ? $clog2(DATA_W) : 3;

  muldiv_state_e       state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quot_q, quot_d;
  logic [DATA_W-1:0]   dvsr_q, dvsr_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                neg_quot_q, neg_quot_d;
  logic                neg_rem_q, neg_rem_d;
  logic                dz_q, dz_d;

  muldiv_op_e          op_sel;
  logic                sign_a, sign_b;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [2*DATA_W-1:0] full_prod;
  logic [DATA_W-1:0]   step_rem, step_quot;
  logic                early_out;

  assign op_sel    = muldiv_op_e'(op_i);
  assign sign_a    = op_is_signed(op_sel) & src_a_i[DATA_W-1];
  assign sign_b    = op_is_signed(op_sel) & src_b_i[DATA_W-1];
  assign abs_a     = sign_a ? (-src_a_i) : src_a_i;
  assign abs_b     = sign_b ? (-src_b_i) : src_b_i;
  assign full_prod = {{DATA_W{1'b0}}, abs_a} * {{DATA_W{1'b0}}, abs_b};

`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = (abs_b > abs_a);
`else
  assign early_out = 1'b0;
`endif

  muldiv_ctrl_div_step #(
    .DATA_W(DATA_W)
  ) u_div_step (
    .rem_i    (rem_q),
    .quot_i   (quot_q),
    .divisor_i(dvsr_q),
    .rem_o    (step_rem),
    .quot_o   (step_quot)
  );

  // Register every piece of state; reset returns to IDLE with all results cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      prod_q     <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prod_q     <= prod_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvsr_q     <= dvsr_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
    end
  end

  // Next-state, datapath updates and pipeline handshake; results land in HI/LO on entry to DONE
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    dvsr_d      = dvsr_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    neg_quot_d  = neg_quot_q;
    neg_rem_d   = neg_rem_q;
    dz_d        = dz_q;
    stall_req_o = 1'b0;
    hilo_we_o   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          stall_req_o = 1'b1;
          dz_d        = 1'b0;
          neg_quot_d  = sign_a ^ sign_b;
          neg_rem_d   = sign_a;
          if (!op_is_div(op_sel)) begin
            prod_d  = full_prod;
            cnt_d   = CNT_W'(MUL_LAT - 1);
            state_d = S_MUL;
          end else if (src_b_i == '0) begin
            lo_d    = '1;
            hi_d    = src_a_i;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else if (early_out) begin
            lo_d    = '0;
            hi_d    = src_a_i;
            state_d = S_DONE;
          end else begin
            rem_d   = '0;
            quot_d  = abs_a;
            dvsr_d  = abs_b;
            cnt_d   = CNT_W'(DATA_W - 1);
            state_d = S_DIV;
          end
        end
      end

      S_MUL: begin
        stall_req_o = 1'b1;
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = neg_quot_q ? (-prod_q) : prod_q;
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DIV: begin
        stall_req_o = 1'b1;
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d  = step_rem;
          quot_d = step_quot;
          if (cnt_q == '0) begin
            lo_d    = neg_quot_q ? (-step_quot) : step_quot;
            hi_d    = neg_rem_q ? (-step_rem) : step_rem;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      S_DONE: begin
        hilo_we_o = !flush_i;
        if (flush_i) begin
          dz_d = 1'b0;
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign busy_o     = (state_q != S_IDLE);
  assign div_zero_o = dz_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases followed by
// randomized operations, all compared against an arithmetic reference
// model (64-bit products, truncating division, stall-length rules).
// Honours MULDIV_EARLY_OUT_EN when computing expected stall lengths.
module tb_muldiv_ctrl;

  localparam int DATA_W  = 32;
  localparam int MUL_LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              startIn;
  logic [1:0]        opIn;
  logic [DATA_W-1:0] srcA, srcB;
  logic              flushIn;
  logic              stallReq, hiloWe, busy, divZero;
  logic [DATA_W-1:0] hiOut, loOut;

  int checkCount = 0;
  int passCount  = 0;

  muldiv_ctrl #(
    .DATA_W (DATA_W),
    .MUL_LAT(MUL_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (startIn),
    .op_i       (opIn),
    .src_a_i    (srcA),
    .src_b_i    (srcB),
    .flush_i    (flushIn),
    .stall_req_o(stallReq),
    .hilo_we_o  (hiloWe),
    .hi_o       (hiOut),
    .lo_o       (loOut),
    .busy_o     (busy),
    .div_zero_o (divZero)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Single comparison point
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Reference model straight from the arithmetic definition of each operation
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] expHi, output logic [31:0] expLo,
                                output int expStalls, output logic expDz);
    longint       sa, sb, ua, ub, q, r, absA, absB;
    logic [63:0]  p, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    expDz = 1'b0;
    if (op[1] == 1'b0) begin
      if (op == 2'b00) p = sa * sb;
      else p = ua * ub;
      expHi = p[63:32];
      expLo = p[31:0];
      expStalls = 1 + MUL_LAT;
    end else if (b == 32'd0) begin
      expHi = a;
      expLo = 32'hFFFF_FFFF;
      expStalls = 1;
      expDz = 1'b1;
    end else begin
      if (op == 2'b10) begin
        q = sa / sb;
        r = sa % sb;
        absA = (sa < 0) ? -sa : sa;
        absB = (sb < 0) ? -sb : sb;
      end else begin
        q = ua / ub;
        r = ua % ub;
        absA = ua;
        absB = ub;
      end
      qv = q;
      rv = r;
      expLo = qv[31:0];
      expHi = rv[31:0];
      expStalls = 1 + DATA_W;
`ifdef MULDIV_EARLY_OUT_EN
      if (absB > absA) expStalls = 1;
`endif
    end
  endfunction

  // Present an op in IDLE and count stall cycles until DONE is reached
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               output int stalls, output logic sawWe);
    @(negedge clk);
    startIn = 1'b1;
    opIn    = op;
    srcA    = a;
    srcB    = b;
    #1;
    stalls = 0;
    while (stallReq === 1'b1 && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    sawWe = hiloWe;
  endtask

  // Run one op end to end and compare DONE-cycle and hold-cycle behaviour
  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit keepStart);
    logic [31:0] expHi, expLo;
    int          expStalls, stalls;
    logic        expDz, sawWe;
    model(op, a, b, expHi, expLo, expStalls, expDz);
    applyStimulus(op, a, b, stalls, sawWe);
    checkOutput("stall_cycles", 64'(stalls), 64'(expStalls));
    checkOutput("hilo_we_done", 64'(sawWe), 64'd1);
    checkOutput("hi", 64'(hiOut), 64'(expHi));
    checkOutput("lo", 64'(loOut), 64'(expLo));
    checkOutput("div_zero", 64'(divZero), 64'(expDz));
    if (!keepStart) begin
      @(negedge clk);
      startIn = 1'b0;
      #1;
      checkOutput("hilo_we_oneshot", 64'(hiloWe), 64'd0);
      checkOutput("busy_idle", 64'(busy), 64'd0);
      checkOutput("hi_hold", 64'(hiOut), 64'(expHi));
      checkOutput("lo_hold", 64'(loOut), 64'(expLo));
      checkOutput("div_zero_sticky", 64'(divZero), 64'(expDz));
    end
  endtask

  initial begin
    logic        weSeen;
    logic [1:0]  rOp;
    logic [31:0] rA, rB;
    int          mode;

    rst = 1'b1; startIn = 1'b0; flushIn = 1'b0; opIn = 2'b00; srcA = '0; srcB = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_stall", 64'(stallReq), 64'd0);
    checkOutput("rst_we", 64'(hiloWe), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_hi", 64'(hiOut), 64'd0);
    checkOutput("rst_lo", 64'(loOut), 64'd0);
    checkOutput("rst_dz", 64'(divZero), 64'd0);
    rst = 1'b0;

    $display("[TB] directed cases");
    runOp(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0);
    runOp(2'b11, 32'd100, 32'd7, 1'b0);
    runOp(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    runOp(2'b10, 32'd5, 32'd0, 1'b0);
    runOp(2'b00, 32'd7, 32'd6, 1'b0);
    runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    runOp(2'b11, 32'd3, 32'd9, 1'b0);
    runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    $display("[TB] back-to-back DIV then MULTU");
    runOp(2'b10, 32'd1234567, 32'hFFFF_FF85, 1'b1);
    runOp(2'b01, 32'h8765_4321, 32'h0001_0003, 1'b0);

    $display("[TB] flush mid-divide");
    @(negedge clk);
    startIn = 1'b1; opIn = 2'b10; srcA = 32'd1000; srcB = 32'd3;
    repeat (9) @(negedge clk);
    flushIn = 1'b1; startIn = 1'b0;
    #1;
    checkOutput("flush_cycle_stall", 64'(stallReq), 64'd1);
    @(negedge clk);
    flushIn = 1'b0;
    #1;
    checkOutput("after_flush_stall", 64'(stallReq), 64'd0);
    checkOutput("after_flush_busy", 64'(busy), 64'd0);
    weSeen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      weSeen = weSeen | hiloWe;
    end
    checkOutput("flush_no_write", 64'(weSeen), 64'd0);

    $display("[TB] flush beats start in IDLE");
    @(negedge clk);
    startIn = 1'b1; flushIn = 1'b1; opIn = 2'b00; srcA = 32'd9; srcB = 32'd9;
    #1;
    checkOutput("flush_start_stall", 64'(stallReq), 64'd0);
    @(negedge clk);
    startIn = 1'b0; flushIn = 1'b0;
    #1;
    checkOutput("flush_start_busy", 64'(busy), 64'd0);

    $display("[TB] reset mid-operation");
    runOp(2'b01, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
    @(negedge clk);
    startIn = 1'b1; opIn = 2'b11; srcA = 32'd77; srcB = 32'd5;
    repeat (5) @(negedge clk);
    rst = 1'b1; startIn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_stall", 64'(stallReq), 64'd0);
    checkOutput("midrst_hi", 64'(hiOut), 64'd0);
    checkOutput("midrst_lo", 64'(loOut), 64'd0);
    checkOutput("midrst_we", 64'(hiloWe), 64'd0);

    $display("[TB] randomized operations");
    for (int n = 0; n < 24; n++) begin
      rOp  = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 3);
      rA   = $urandom;
      rB   = $urandom;
      if (mode == 1) begin
        rA = 32'($signed($urandom_range(0, 40)) - 20);
        rB = 32'($signed($urandom_range(0, 40)) - 20);
      end else if (mode == 2) begin
        rB = 32'd0;
      end else if (mode == 3) begin
        rA = 32'($urandom_range(0, 50));
      end
      runOp(rOp, rA, rB, ($urandom_range(0, 3) == 0));
    end
    @(negedge clk);
    startIn = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
